// File: rtl/prog_clk_div_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
package prog_clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/prog_clk_div_ch.sv
// One divider channel: active/pending ratio, period counter and registered outputs.
module prog_clk_div_ch
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic          sync_i,
  input  logic [CW-1:0] div_i,
  output logic          clk_o,
  output logic          tick_o,
  output logic          ack_o
);

  ch_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] a_q, a_d;
  logic [CW-1:0] p_q, p_d;
  logic          pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] e_cur_c, e_nxt_c;
  logic          boundary_c;
  logic          apply_c;

  // Ratios 0 and 1 behave as MIN_DIV.
  assign e_cur_c    = (a_q < CW'(MIN_DIV)) ? CW'(MIN_DIV) : a_q;
  assign e_nxt_c    = (a_d < CW'(MIN_DIV)) ? CW'(MIN_DIV) : a_d;
  assign boundary_c = (cnt_q == (e_cur_c - CW'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      a_q    <= CW'(MIN_DIV);
      p_q    <= CW'(MIN_DIV);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      p_q    <= p_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
    end
  end

  // Next state: a pending ratio is promoted only while idle or on a period restart.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    apply_c = 1'b0;
    unique case (st_q)
      IDLE: begin
        cnt_d   = '0;
        apply_c = pend_q;
        if (en_i) st_d = RUN;
      end
      RUN: begin
        if (boundary_c || sync_i) begin
          cnt_d   = '0;
          apply_c = pend_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (boundary_c && !en_i) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (apply_c) begin
      a_d    = p_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    // A load seen on a restart edge lands in P after the promotion above.
    if (load_i) begin
      p_d    = div_i;
      pend_d = 1'b1;
    end
  end

  // Output decode from next state so the outputs leave flops aligned with cnt.
  always_comb begin
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (st_d == RUN) begin
      clk_d  = (cnt_d >= (e_nxt_c >> 1));
      tick_d = (cnt_d == '0);
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign ack_o  = ack_q;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable clock divider, NCH independent channels.
// Define PROG_CLK_DIV_SYNC_EN to add sync_i, which restarts all running channels.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [NCH-1:0]    en_i,
  input  logic [NCH*CW-1:0] div_i,
  input  logic [NCH-1:0]    load_i,
  output logic [NCH-1:0]    clk_o,
  output logic [NCH-1:0]    tick_o,
  output logic [NCH-1:0]    ack_o
);

  logic sync_c;

`ifdef PROG_CLK_DIV_SYNC_EN
  assign sync_c = sync_i;
`else
  assign sync_c = 1'b0;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    prog_clk_div_ch #(
      .CW (CW)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i[k]),
      .load_i (load_i[k]),
      .sync_i (sync_c),
      .div_i  (div_i[k*CW +: CW]),
      .clk_o  (clk_o[k]),
      .tick_o (tick_o[k]),
      .ack_o  (ack_o[k])
    );
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CW, default 8: divide-ratio and counter width in bits.
REQ-003 SHALL have port clk_i  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en_i  input  NCH  per-channel run enable, level.
REQ-006 SHALL have port div_i  input  NCH*CW  per-channel divide ratio N, channel k in bits [k*CW +: CW].
REQ-007 SHALL have port load_i  input  NCH  per-channel one-cycle request to capture div_i.
REQ-008 SHALL have port clk_o  output  NCH  divided clocks, registered.
REQ-009 SHALL have port tick_o  output  NCH  one-cycle pulse on the first clk_i cycle of each output period.
REQ-010 SHALL have port ack_o  output  NCH  one-cycle pulse when a pending ratio becomes active.

Function
REQ-011 Each channel SHALL hold an active ratio A, a pending ratio P with a pending flag, a counter cnt (CW bits) and state IDLE or RUN.
REQ-012 Effective ratio SHALL be E = max(A, 2); div values 0 and 1 are accepted and behave as 2.
REQ-013 In RUN, cnt SHALL count 0..E-1 and wrap to 0; clk_o SHALL be 1 exactly when cnt >= E/2 (integer divide), giving low phase floor(E/2) cycles and high phase ceil(E/2) cycles.
REQ-014 tick_o SHALL be 1 in every cycle where a RUN channel has cnt == 0.
REQ-015 IDLE -> RUN when en_i=1; the first RUN cycle SHALL have cnt=0, tick_o=1, clk_o=0.
REQ-016 en_i deassert in RUN SHALL NOT truncate the period: the channel SHALL continue to cnt == E-1, then enter IDLE with cnt=0, clk_o=0; re-assert before then cancels the stop.
REQ-017 load_i=1 SHALL capture div_i into P and set pending in the next cycle; a second load before application SHALL overwrite P (last wins, one ack).
REQ-018 Pending P SHALL become A only at a period boundary (transition cnt E-1 -> 0) or immediately when the channel is IDLE; ack_o SHALL pulse in the cycle A updates.
REQ-019 load_i coincident with a boundary SHALL apply the newly loaded value at the following boundary, not the current one.
REQ-020 Channels SHALL be fully independent; no output of one channel depends on another channel's inputs.
REQ-021 clk_o SHALL never produce a high or low pulse shorter than floor(min(old E, new E)/2) cycles across a ratio change or stop.

Reset
REQ-022 rst_i SHALL asynchronously force every channel to IDLE, cnt=0, A=2, P=2, pending=0, clk_o=0, tick_o=0, ack_o=0.
REQ-023 Reset mid-period SHALL discard the period and any pending load; operation resumes per REQ-015 after release.

Configuration
REQ-024 Macro PROG_CLK_DIV_SYNC_EN, when defined, SHALL add port sync_i input 1: sync_i=1 forces cnt=0 in all RUN channels in the next cycle (clk_o=0, tick_o=1), applying any pending ratio with ack.
REQ-025 Without PROG_CLK_DIV_SYNC_EN the sync_i port SHALL not exist and channels free-run per REQ-013.

Structure
REQ-026 Shared package prog_clk_div_pkg SHALL hold the channel state enum (IDLE, RUN) and constant MIN_DIV = 2.
REQ-027 Per-channel logic SHALL be sub-module prog_clk_div_ch, instantiated NCH times by a generate loop in prog_clk_div.

Verification
REQ-028 Reset, en_i[0]=1, A=2 default -> clk_o[0] toggles 0,1,0,1 each cycle, tick_o every 2 cycles.
REQ-029 load div=5 on ch0 while running -> ack_o[0] at next boundary; then clk_o low 2, high 3 cycles, tick_o every 5.
REQ-030 div=7 running, en_i dropped at cnt=1 -> clk_o completes high phase through cnt=6, then IDLE, clk_o=0.
REQ-031 div=0 and div=1 loaded -> identical output to div=2.
REQ-032 ch0 div=3, ch1 div=4 simultaneously -> periods 3 and 4, no interaction; rst_i pulsed mid-period -> all outputs 0 same cycle.
REQ-033 With PROG_CLK_DIV_SYNC_EN: ch0 div=4, ch1 div=6 free-running, sync_i pulse -> both tick_o=1 next cycle, clk_o both 0.
